// File: rtl/wave_display_reader_if.sv
// rtl/wave_display_reader_if.sv - pixel stream, sample RAM read port and colour output bundle
//
// Purpose: groups the signals between the waveform display reader and its
// surroundings (VGA timing, sample RAM, colour output, capture handshake).
// Ports (all carried as interface signals):
//   x[10:0], y[9:0], valid     current pixel position and visibility
//   read_index                 RAM half owned by the display
//   read_address[8:0]          RAM read address {half, sample index}
//   read_value[7:0]            RAM data for the registered read_address
//   valid_pixel, r, g, b       delayed pixel valid and colour
//   wave_display_idle          display not scanning the window
// Modports: master = environment side, slave = reader side.
interface wave_display_reader_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [8:0]  read_address;
    logic [7:0]  read_value;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        wave_display_idle;

    modport master (
        output x, y, valid, read_index, read_value,
        input  read_address, valid_pixel, r, g, b, wave_display_idle
    );

    modport slave (
        input  x, y, valid, read_index, read_value,
        output read_address, valid_pixel, r, g, b, wave_display_idle
    );
endinterface

// File: rtl/wave_display_reader.sv
// rtl/wave_display_reader.sv - read side of the double-buffered waveform RAM, draws the trace
//
// Purpose: scans the display-owned half of the sample RAM in step with the
// pixel stream and colours a 512x256 trace window; reports idle between frames
// so the capture side can swap halves without tearing.
// Ports:
//   clk    system clock
//   reset  synchronous reset, active-high
//   bus    wave_display_reader_if.slave (pixel in, RAM port, colour out, idle)
// Pipeline: stage 0 registers address/window/row/index, stage 1 compares the
// sample against the row and registers colour; two cycles pixel to colour.
module wave_display_reader #(
    parameter int X_START = 64,
    parameter int Y_START = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    wave_display_reader_if.slave        bus
);
    localparam logic [11:0] X_LO  = 12'(X_START);
    localparam logic [11:0] X_HI  = 12'(X_START + 512);
    localparam logic [10:0] Y_LO  = 11'(Y_START);
    localparam logic [10:0] Y_HI  = 11'(Y_START + 256);
    localparam logic [9:0]  Y_TOP = 10'(Y_START + 255);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0] state;
    logic       idx_q;
    logic [9:0] y_last;
    logic       row_seen;

    // stage 0 registers
    logic       win_q;
    logic       valid_q;
    logic       first_q;
    logic [7:0] k_q;
    logic [7:0] row_q;

    // per-row trace history: the sample currently being drawn and the one before it
    logic [7:0] last_k;
    logic [7:0] last_val;
    logic [7:0] prev_val;

    // stage 0 combinational
    logic       in_win;
    logic [7:0] k;
    logic [7:0] row;
    logic       entry;
    logic       idx_sel;
    logic       row_change;
    logic       first;

    always_comb begin
        in_win     = bus.valid
                     && ({1'b0, bus.x} >= X_LO) && ({1'b0, bus.x} < X_HI)
                     && ({1'b0, bus.y} >= Y_LO) && ({1'b0, bus.y} < Y_HI);
        k          = 8'((bus.x - X_LO[10:0]) >> 1);
        row        = 8'(Y_TOP - bus.y);
        entry      = (state == S_IDLE) && bus.valid && (bus.y == Y_LO[9:0]);
        // the entry pixel must already address the newly owned half
        idx_sel    = entry ? bus.read_index : idx_q;
        row_change = (bus.y != y_last);
        first      = (k == 8'd0) || !row_seen || row_change;
    end

    // stage 1 combinational
    logic [7:0] cur;
    logic [7:0] prv;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       lit;

    always_comb begin
        cur = bus.read_value;
        if (first_q) begin
            prv = cur;
        end else if (k_q == last_k) begin
            // second column of the same sample: keep the neighbour, not itself
            prv = prev_val;
        end else begin
            prv = last_val;
        end
        lo  = (prv < cur) ? prv : cur;
        hi  = (prv < cur) ? cur : prv;
        lit = (row_q >= lo) && (row_q <= hi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            idx_q            <= 1'b0;
            y_last           <= '0;
            row_seen         <= 1'b0;
            bus.read_address <= '0;
            win_q            <= 1'b0;
            valid_q          <= 1'b0;
            first_q          <= 1'b0;
            k_q              <= '0;
            row_q            <= '0;
            last_k           <= '0;
            last_val         <= '0;
            prev_val         <= '0;
            bus.valid_pixel  <= 1'b0;
            bus.r            <= '0;
            bus.g            <= '0;
            bus.b            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (entry) begin
                        state <= S_ACTIVE;
                        idx_q <= bus.read_index;
                    end
                end
                default: begin
                    if ((bus.valid && ({1'b0, bus.y} >= Y_HI)) || ({1'b0, bus.y} < Y_LO)) begin
                        state <= S_IDLE;
                    end
                end
            endcase

            y_last   <= bus.y;
            row_seen <= (row_change ? 1'b0 : row_seen) | in_win;

            if (in_win) begin
                bus.read_address <= {idx_sel, k};
            end
            win_q   <= in_win;
            valid_q <= bus.valid;
            first_q <= first;
            k_q     <= k;
            row_q   <= row;

            if (win_q && (first_q || (k_q != last_k))) begin
                prev_val <= first_q ? cur : last_val;
                last_val <= cur;
                last_k   <= k_q;
            end

            bus.valid_pixel <= valid_q;
            bus.r <= (win_q && lit) ? 8'hFF : 8'h00;
            bus.g <= (win_q && lit) ? 8'hFF : 8'h00;
            bus.b <= win_q ? (lit ? 8'hFF : 8'h40) : 8'h00;
        end
    end

    assign bus.wave_display_idle = (state == S_IDLE);
endmodule

// File: tb/tb_wave_display_reader.sv
// tb/tb_wave_display_reader.sv - directed self-checking bench for wave_display_reader
module tb_wave_display_reader;
    localparam logic [24:0] WHITE = {1'b1, 24'hFFFFFF};
    localparam logic [24:0] BLUE  = {1'b1, 24'h000040};
    localparam logic [24:0] BLACK = {1'b1, 24'h000000};
    localparam logic [24:0] OFF   = 25'h0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wave_display_reader_if bus();

    wave_display_reader #(.X_START(64), .Y_START(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // sample RAM: data for the address the reader registered on the previous edge
    logic [7:0] ram [0:511];
    assign bus.read_value = ram[bus.read_address];

    int tests_run = 0;
    int tests_failed = 0;

    logic [24:0] pipe0, pipe1;
    string       tag0, tag1;
    logic        exp_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one pixel per cycle; output seen now belongs to the pixel driven two cycles ago
    task automatic cyc(input logic [10:0] px, input logic [9:0] py, input logic pv,
                       input logic [24:0] ex, input logic rst);
        @(posedge clk);
        #1;
        bus.x     = px;
        bus.y     = py;
        bus.valid = pv;
        reset     = rst;
        @(negedge clk);
        check(tag1, {7'd0, bus.valid_pixel, bus.r, bus.g, bus.b}, {7'd0, pipe1});
        if (rst) begin
            pipe1 = OFF; tag1 = "after_reset";
            pipe0 = OFF; tag0 = "after_reset";
        end else begin
            pipe1 = pipe0; tag1 = tag0;
            pipe0 = ex;    tag0 = $sformatf("pix x=%0d y=%0d v=%0d", px, py, pv);
        end
    endtask

    // scan a run of valid pixels on one row; optional 3-cycle bubble before gap_x
    task automatic scan(input logic [9:0] py, input int x0, input int x1, input int gap_x);
        int first_k, kk, cur, prv, row, lo, hi;
        logic [24:0] ex;
        first_k = -1;
        for (int xx = x0; xx <= x1; xx++) begin
            if (xx == gap_x) repeat (3) cyc(11'(xx), py, 1'b0, OFF, 1'b0);
            if (xx < 64 || xx >= 576 || py < 32 || py >= 288) begin
                ex = BLACK;
            end else begin
                kk = (xx - 64) / 2;
                if (first_k < 0) first_k = kk;
                cur = int'(ram[{exp_idx, 8'(kk)}]);
                prv = (kk == first_k) ? cur : int'(ram[{exp_idx, 8'(kk - 1)}]);
                row = 287 - int'(py);
                lo  = (prv < cur) ? prv : cur;
                hi  = (prv < cur) ? cur : prv;
                ex  = (row >= lo && row <= hi) ? WHITE : BLUE;
            end
            cyc(11'(xx), py, 1'b1, ex, 1'b0);
        end
    endtask

    initial begin
        bus.x = '0; bus.y = '0; bus.valid = 1'b0; bus.read_index = 1'b0;
        reset = 1'b1;
        pipe0 = OFF; pipe1 = OFF; tag0 = "reset"; tag1 = "reset";
        exp_idx = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]       = (i < 10) ? 8'd10 : 8'd200;
            ram[256 + i] = 8'd128;
        end

        // reset then idle
        cyc(11'd0, 10'd0, 1'b0, OFF, 1'b1);
        cyc(11'd0, 10'd0, 1'b0, OFF, 1'b1);
        cyc(11'd0, 10'd0, 1'b0, OFF, 1'b0);
        check("idle_reset", bus.wave_display_idle, 1);
        check("vp_reset", bus.valid_pixel, 0);
        check("rgb_reset", {bus.r, bus.g, bus.b}, 0);
        check("addr_reset", bus.read_address, 0);

        // frame 1: half 1 (flat 128), index toggled mid-frame
        bus.read_index = 1'b1; exp_idx = 1'b1;
        scan(10'd31, 64, 65, -1);
        scan(10'd32, 64, 64, -1);
        check("idle_before_latch", bus.wave_display_idle, 1);
        scan(10'd32, 65, 65, -1);
        check("idle_fall", bus.wave_display_idle, 0);
        check("addr_latch_idx1", bus.read_address, 9'h100);
        scan(10'd32, 66, 577, -1);
        bus.read_index = 1'b0;
        scan(10'd159, 62, 577, -1);
        check("addr_frozen_a", bus.read_address, 9'h1FF);
        scan(10'd158, 62, 577, -1);
        check("addr_frozen_b", bus.read_address[8], 1);
        scan(10'd287, 64, 67, -1);
        check("idle_last_row", bus.wave_display_idle, 0);
        scan(10'd288, 64, 64, -1);
        check("idle_before_rise", bus.wave_display_idle, 0);
        scan(10'd288, 65, 65, -1);
        check("idle_rise", bus.wave_display_idle, 1);

        // frame 2: half 0 holds the step 10 -> 200 between samples 9 and 10
        exp_idx = 1'b0;
        scan(10'd31, 64, 64, -1);
        scan(10'd32, 64, 65, -1);
        check("idle_fall2", bus.wave_display_idle, 0);
        scan(10'd87, 80, 89, -1);
        scan(10'd86, 80, 89, -1);
        scan(10'd277, 80, 89, -1);
        check("addr_idx0", bus.read_address, 9'h00C);
        scan(10'd278, 80, 89, -1);
        // row 87 by hand: sample 9 (10,10) unlit, step 10..200 lit, flat 200 unlit
        cyc(11'd82, 10'd200, 1'b1, BLUE,  1'b0);
        cyc(11'd83, 10'd200, 1'b1, BLUE,  1'b0);
        cyc(11'd84, 10'd200, 1'b1, WHITE, 1'b0);
        cyc(11'd85, 10'd200, 1'b1, WHITE, 1'b0);
        cyc(11'd86, 10'd200, 1'b1, BLUE,  1'b0);
        cyc(11'd87, 10'd200, 1'b1, BLUE,  1'b0);

        // bubbles mid-row, then reset mid-window
        scan(10'd100, 80, 89, 84);
        cyc(11'd90, 10'd100, 1'b1, OFF, 1'b1);
        cyc(11'd91, 10'd100, 1'b0, OFF, 1'b0);
        check("idle_after_reset", bus.wave_display_idle, 1);
        check("addr_after_reset", bus.read_address, 0);

        // next window entry re-latches the index
        bus.read_index = 1'b1; exp_idx = 1'b1;
        scan(10'd31, 64, 64, -1);
        scan(10'd32, 64, 65, -1);
        check("addr_relatch", bus.read_address, 9'h100);
        check("idle_relatch", bus.wave_display_idle, 0);
        cyc(11'd0, 10'd32, 1'b0, OFF, 1'b0);
        cyc(11'd0, 10'd32, 1'b0, OFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/wave_display_reader.md
# wave_display_reader

Read side of the double-buffered waveform sample RAM. `wave_capture` fills one 256-entry half. This block scans the other half, selected by `read_index`, in step with the VGA pixel stream and produces per-pixel colour for the waveform trace. It tells the capture side when the display is not reading, through `wave_display_idle`, so the capture side can swap halves between frames without tearing.

## Interface
Parameters:
- `X_START`, default 64: first pixel column of the trace window.
- `Y_START`, default 32: first pixel row of the trace window.
- The window is fixed at 512 columns × 256 rows.
- Each sample spans 2 columns.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `x`  in  11  current pixel column.
- `y`  in  10  current pixel row.
- `valid`  in  1  `x`/`y` describe a visible pixel this cycle.
- `read_index`  in  1  RAM half currently owned by the display.
- `read_address`  out  9  RAM read address, formed as {`read_index` latched, sample index[7:0]}.
- `read_value`  in  8  RAM data. Unsigned; 128 is zero level. Valid 1 cycle after `read_address`.
- `valid_pixel`  out  1  `valid` delayed 2 cycles.
- `r`, `g`, `b`  out  8 each  pixel colour.
- `wave_display_idle`  out  1  high while the display is not scanning the window.

## Operation
- Reset values:
  - `read_address` = 0.
  - `valid_pixel` = 0.
  - `r`/`g`/`b` = 0.
  - FSM in IDLE, so `wave_display_idle` = 1.
- In-window test: `valid`, X_START ≤ `x` < X_START+512, and Y_START ≤ `y` < Y_START+256.
- Sample index: k = (`x` − X_START) >> 1.
- Row value: row = (Y_START+255) − `y`. The top window row is 255; the bottom row is 0.
- FSM states:
  - IDLE → ACTIVE: on the first cycle that is `valid` with `y` == Y_START. On that same cycle, `read_index` is latched into `idx_q`.
  - ACTIVE → IDLE: on the first `valid` cycle with `y` ≥ Y_START+256, or when `y` < Y_START (frame wrap).
- `wave_display_idle` is 1 exactly in IDLE.
- `idx_q` is frozen while in ACTIVE. A `read_index` toggle mid-frame takes effect only at the next IDLE→ACTIVE transition.
- `read_address`:
  - Registered {`idx_q`, k} for in-window pixels.
  - Holds its last value otherwise.
  - On the IDLE→ACTIVE cycle, it uses the newly latched index.
- Trace, evaluated at stage 1 for the pixel whose sample index is k:
  - cur = `read_value`, i.e. RAM[k].
  - prev = the last read sample in the current row with an index ≠ k.
  - On the first sample of a row (k = 0, or the first in-window pixel of the row), prev = cur.
- Lit iff min(prev, cur) ≤ row ≤ max(prev, cur), all unsigned 8-bit compares. No arithmetic overflow is possible.
- Colour when `valid_pixel` = 1:
  - Lit in-window pixel: (FF, FF, FF).
  - Unlit in-window pixel: (00, 00, 40).
  - Out of window: (00, 00, 00).
- When `valid_pixel` = 0, `r`/`g`/`b` = 0.
- The prev tracking resets at each new row, i.e. when `y` changes.

## Timing
- Pipeline stage 0 (edge after input): `read_address`, registered in-window flag, row, k, and `valid` delay.
- Stage 1: `read_value` is available; the lit compare is done and prev/cur are updated.
- Outputs are registered.
- Latency: pixel presented at cycle n → `r`/`g`/`b`/`valid_pixel` valid at cycle n+2.
- The pipeline advances every cycle regardless of `valid`. `valid` = 0 bubbles propagate and produce black.
- `wave_display_idle`:
  - Changes on the clock edge after the qualifying `x`/`y`.
  - Falls the cycle after the first window-row pixel is seen.
  - Rises the cycle after the first below-window row is seen.
- Reset mid-frame:
  - The pipeline clears within 1 cycle and all outputs go to reset values.
  - The next window entry re-latches `read_index`.
- A simultaneous row change and window entry are handled in the same cycle: prev is cleared and the new address is issued.

## Test plan
- **Reset then idle:**
  - Stimulus: hold `reset` 2 cycles, then `valid` = 0.
  - Required: `wave_display_idle` = 1, `valid_pixel` = 0, rgb = 0, `read_address` = 0.
- **Index latch and freeze:**
  - Stimulus: `read_index` = 1, first pixel (x = 64, y = 32); toggle `read_index` to 0 mid-frame.
  - Required: `read_address` = 9'h100 one cycle later; `read_address`[8] stays 1 until the next frame.
- **Flat trace, model RAM with 1-cycle latency, all samples = 128:**
  - Row y = 159 (row 128): 512 white pixels at n+2.
  - Row y = 158: all (00, 00, 40).
  - x = 63 and x = 576: black.
- **Step:**
  - Stimulus: RAM[9] = 10, RAM[10] = 200.
  - Required: pixels x = 84..85 lit for rows 10..200 (y = 87..277); x = 82..83 lit only at row 10.
- **Idle handshake:**
  - Stimulus: scan y = 31 → 32 → 287 → 288.
  - Required: `wave_display_idle` falls 1 cycle after the first y = 32 valid pixel and rises 1 cycle after the first y = 288 valid pixel.
- **Bubbles and reset mid-frame:**
  - Stimulus: `valid` gap of 3 cycles mid-row, then `reset` asserted mid-window.
  - Required: 3 black, `valid_pixel` = 0 outputs, aligned at n+2, with the trace continuing correctly after the gap. After reset, outputs are 0 next cycle and `wave_display_idle` = 1.
